// File: rtl/pkt_filter.sv
`default_nettype none
// ============================================================================
// Module   : pkt_filter
// Brief    : VLAN/IPv4/UDP ingress classifier; steers each packet whole to
//            the data output, the control output, or drops it.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_filter #(
   parameter int          C_S_AXIS_DATA_WIDTH  = 256,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [15:0] CTRL_UDP_PORT        = 16'hf2f1
) (
   input  logic                                 axis_clk,
   input  logic                                 areset,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
   input  logic                                 s_axis_tvalid,
   input  logic                                 s_axis_tlast,
   output logic                                 s_axis_tready,

   output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
   output logic                                 m_axis_tvalid,
   output logic                                 m_axis_tlast,
   input  logic                                 m_axis_tready,

   output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
   output logic                                 c_m_axis_tvalid,
   output logic                                 c_m_axis_tlast,
   input  logic                                 c_m_axis_tready,

   output logic [31:0]                          drop_cnt,
   output logic [31:0]                          ctrl_cnt
);

   localparam int          C_DW      = C_S_AXIS_DATA_WIDTH;
   localparam int          C_UW      = C_S_AXIS_TUSER_WIDTH;
   localparam int          C_KW      = C_S_AXIS_DATA_WIDTH / 8;
   localparam logic [31:0] C_CNT_MAX = 32'hffff_ffff;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLASSIFY = 3'd1,
      S_FWD_DATA = 3'd2,
      S_FWD_CTRL = 3'd3,
      S_DROP     = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [C_DW-1:0]   r_hold_data;
   logic [C_UW-1:0]   r_hold_user;
   logic [C_KW-1:0]   r_hold_keep;
   logic              r_hold_last;
   logic              r_hold_valid;

   logic [C_DW-1:0]   r_m_data;
   logic [C_UW-1:0]   r_m_user;
   logic [C_KW-1:0]   r_m_keep;
   logic              r_m_last;
   logic              r_m_valid;

   logic [C_DW-1:0]   r_c_data;
   logic [C_UW-1:0]   r_c_user;
   logic [C_KW-1:0]   r_c_keep;
   logic              r_c_last;
   logic              r_c_valid;

   logic [31:0]       r_drop_cnt;
   logic [31:0]       r_ctrl_cnt;

   logic              w_m_free;
   logic              w_c_free;
   logic              w_tready;
   logic              w_accept;
   logic              w_beat_vlan;
   logic              w_hold_vlan;
   logic              w_hold_ctrl_hdr;
   logic              w_beat_ctrl_port;
   logic              w_hold_load;
   logic              w_hold_clr;
   logic              w_m_load_in;
   logic              w_m_load_hold;
   logic              w_c_load_hold;
   logic              w_drop_inc;
   logic              w_ctrl_inc;

   assign w_m_free         = !r_m_valid || m_axis_tready;
   assign w_c_free         = !r_c_valid || c_m_axis_tready;
   assign s_axis_tready    = w_tready && !areset;
   assign w_accept         = s_axis_tvalid && s_axis_tready;

   // Beat-0 header fields are read from the incoming beat (single-beat case)
   // or from hold (multi-beat case, decided on the beat-1 handshake).
   assign w_beat_vlan      = (s_axis_tdata[96+:16] == 16'h0081);
   assign w_hold_vlan      = (r_hold_data[96+:16] == 16'h0081);
   assign w_hold_ctrl_hdr  = w_hold_vlan
                             && (r_hold_data[128+:16] == 16'h0008)
                             && (r_hold_data[216+:8] == 8'h11);
   assign w_beat_ctrl_port = (s_axis_tdata[64+:16] == CTRL_UDP_PORT);

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_tready      = 1'b0;
      w_hold_load   = 1'b0;
      w_hold_clr    = 1'b0;
      w_m_load_in   = 1'b0;
      w_m_load_hold = 1'b0;
      w_c_load_hold = 1'b0;
      w_drop_inc    = 1'b0;
      w_ctrl_inc    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A single-beat packet goes straight to the data register.
            w_tready = !r_hold_valid && w_m_free;
            if (w_accept) begin
               if (!s_axis_tlast) begin
                  w_hold_load = 1'b1;
                  w_state_nxt = S_CLASSIFY;
               end else if (w_beat_vlan) begin
                  w_m_load_in = 1'b1;
               end else begin
                  w_drop_inc  = 1'b1;
               end
            end
         end
         S_CLASSIFY: begin
            w_tready = w_m_free && w_c_free;
            if (w_accept) begin
               if (w_hold_ctrl_hdr && w_beat_ctrl_port) begin
                  w_c_load_hold = 1'b1;
                  w_hold_load   = 1'b1;
                  w_ctrl_inc    = 1'b1;
                  w_state_nxt   = S_FWD_CTRL;
               end else if (w_hold_vlan) begin
                  w_m_load_hold = 1'b1;
                  w_hold_load   = 1'b1;
                  w_state_nxt   = S_FWD_DATA;
               end else begin
                  w_hold_clr    = 1'b1;
                  w_drop_inc    = 1'b1;
                  w_state_nxt   = s_axis_tlast ? S_IDLE : S_DROP;
               end
            end
         end
         S_FWD_DATA: begin
            w_m_load_hold = r_hold_valid && w_m_free;
            w_tready      = !r_hold_valid || (w_m_load_hold && !r_hold_last);
            if (w_accept) begin
               w_hold_load = 1'b1;
            end else if (w_m_load_hold) begin
               w_hold_clr  = 1'b1;
            end
            if (w_m_load_hold && r_hold_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FWD_CTRL: begin
            w_c_load_hold = r_hold_valid && w_c_free;
            w_tready      = !r_hold_valid || (w_c_load_hold && !r_hold_last);
            if (w_accept) begin
               w_hold_load = 1'b1;
            end else if (w_c_load_hold) begin
               w_hold_clr  = 1'b1;
            end
            if (w_c_load_hold && r_hold_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DROP: begin
            w_tready = 1'b1;
            if (w_accept && s_axis_tlast) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         r_hold_data  <= '0;
         r_hold_user  <= '0;
         r_hold_keep  <= '0;
         r_hold_last  <= 1'b0;
         r_hold_valid <= 1'b0;
      end else if (w_hold_load) begin
         r_hold_data  <= s_axis_tdata;
         r_hold_user  <= s_axis_tuser;
         r_hold_keep  <= s_axis_tkeep;
         r_hold_last  <= s_axis_tlast;
         r_hold_valid <= 1'b1;
      end else if (w_hold_clr) begin
         r_hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         r_m_data  <= '0;
         r_m_user  <= '0;
         r_m_keep  <= '0;
         r_m_last  <= 1'b0;
         r_m_valid <= 1'b0;
      end else if (w_m_load_in) begin
         r_m_data  <= s_axis_tdata;
         r_m_user  <= s_axis_tuser;
         r_m_keep  <= s_axis_tkeep;
         r_m_last  <= s_axis_tlast;
         r_m_valid <= 1'b1;
      end else if (w_m_load_hold) begin
         r_m_data  <= r_hold_data;
         r_m_user  <= r_hold_user;
         r_m_keep  <= r_hold_keep;
         r_m_last  <= r_hold_last;
         r_m_valid <= 1'b1;
      end else if (m_axis_tready) begin
         r_m_valid <= 1'b0;
      end
   end

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         r_c_data  <= '0;
         r_c_user  <= '0;
         r_c_keep  <= '0;
         r_c_last  <= 1'b0;
         r_c_valid <= 1'b0;
      end else if (w_c_load_hold) begin
         r_c_data  <= r_hold_data;
         r_c_user  <= r_hold_user;
         r_c_keep  <= r_hold_keep;
         r_c_last  <= r_hold_last;
         r_c_valid <= 1'b1;
      end else if (c_m_axis_tready) begin
         r_c_valid <= 1'b0;
      end
   end

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         r_drop_cnt <= '0;
         r_ctrl_cnt <= '0;
      end else begin
         if (w_drop_inc && (r_drop_cnt != C_CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
         end
         if (w_ctrl_inc && (r_ctrl_cnt != C_CNT_MAX)) begin
            r_ctrl_cnt <= r_ctrl_cnt + 32'd1;
         end
      end
   end

   assign m_axis_tdata    = r_m_data;
   assign m_axis_tuser    = r_m_user;
   assign m_axis_tkeep    = r_m_keep;
   assign m_axis_tlast    = r_m_last;
   assign m_axis_tvalid   = r_m_valid;

   assign c_m_axis_tdata  = r_c_data;
   assign c_m_axis_tuser  = r_c_user;
   assign c_m_axis_tkeep  = r_c_keep;
   assign c_m_axis_tlast  = r_c_last;
   assign c_m_axis_tvalid = r_c_valid;

   assign drop_cnt        = r_drop_cnt;
   assign ctrl_cnt        = r_ctrl_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pkt_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_filter
// Brief    : Directed and randomized bench for pkt_filter against a
//            packet-level classification model and output scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_filter;

   typedef struct packed {
      logic [255:0] d;
      logic [127:0] u;
      logic [31:0]  k;
      logic         l;
   } beat_t;

   localparam int D_DROP = 0;
   localparam int D_DATA = 1;
   localparam int D_CTRL = 2;

   logic         clk = 1'b0;
   logic         areset = 1'b1;
   logic [255:0] s_axis_tdata = '0;
   logic [127:0] s_axis_tuser = '0;
   logic [31:0]  s_axis_tkeep = '0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tlast = 1'b0;
   logic         s_axis_tready;
   logic [255:0] m_axis_tdata;
   logic [127:0] m_axis_tuser;
   logic [31:0]  m_axis_tkeep;
   logic         m_axis_tvalid;
   logic         m_axis_tlast;
   logic         m_axis_tready = 1'b1;
   logic [255:0] c_m_axis_tdata;
   logic [127:0] c_m_axis_tuser;
   logic [31:0]  c_m_axis_tkeep;
   logic         c_m_axis_tvalid;
   logic         c_m_axis_tlast;
   logic         c_m_axis_tready = 1'b1;
   logic [31:0]  drop_cnt;
   logic [31:0]  ctrl_cnt;

   int    n_checks = 0;
   int    n_pass   = 0;
   int    cyc      = 0;
   int    exp_drop = 0;
   int    exp_ctrl = 0;
   int    in_stalls = 0;
   bit    rand_ready = 1'b0;
   beat_t pkt[$];
   beat_t exp_m[$];
   beat_t exp_c[$];
   int    acc_cyc[$];
   int    m_app[$];

   pkt_filter dut (
      .axis_clk        (clk),
      .areset          (areset),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tuser    (s_axis_tuser),
      .s_axis_tkeep    (s_axis_tkeep),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tready   (s_axis_tready),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tuser    (m_axis_tuser),
      .m_axis_tkeep    (m_axis_tkeep),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tready   (m_axis_tready),
      .c_m_axis_tdata  (c_m_axis_tdata),
      .c_m_axis_tuser  (c_m_axis_tuser),
      .c_m_axis_tkeep  (c_m_axis_tkeep),
      .c_m_axis_tvalid (c_m_axis_tvalid),
      .c_m_axis_tlast  (c_m_axis_tlast),
      .c_m_axis_tready (c_m_axis_tready),
      .drop_cnt        (drop_cnt),
      .ctrl_cnt        (ctrl_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Builds a packet of n beats with the requested header properties.
   task automatic build_pkt(input int n, input bit vlan, input bit ipv4, input bit udp, input bit cport);
      beat_t b;
      pkt.delete();
      for (int i = 0; i < n; i++) begin
         for (int w = 0; w < 8; w++) b.d[w*32 +: 32] = $urandom();
         for (int w = 0; w < 4; w++) b.u[w*32 +: 32] = $urandom();
         b.k = (i == n - 1) ? ($urandom() | 32'h1) : 32'hffff_ffff;
         b.l = (i == n - 1);
         if (i == 0) begin
            b.d[96 +: 16]  = vlan ? 16'h0081 : 16'h0008;
            b.d[128 +: 16] = ipv4 ? 16'h0008 : 16'hdd86;
            b.d[216 +: 8]  = udp ? 8'h11 : 8'h06;
         end
         if (i == 1) begin
            b.d[64 +: 16]  = cport ? 16'hf2f1 : 16'h3500;
         end
         pkt.push_back(b);
      end
   endtask

   function automatic int model_dest();
      if (pkt[0].d[96 +: 16] != 16'h0081) return D_DROP;
      if (pkt.size() == 1) return D_DATA;
      if (pkt[0].d[128 +: 16] == 16'h0008 && pkt[0].d[216 +: 8] == 8'h11
          && pkt[1].d[64 +: 16] == 16'hf2f1) return D_CTRL;
      return D_DATA;
   endfunction

   // Called and returns at posedge+1; drives one beat until accepted.
   task automatic send_beat(input beat_t b);
      bit acc;
      int waited = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b.d;
      s_axis_tuser  = b.u;
      s_axis_tkeep  = b.k;
      s_axis_tlast  = b.l;
      forever begin
         @(negedge clk);
         acc = s_axis_tready;
         if (acc) acc_cyc.push_back(cyc);
         else in_stalls++;
         @(posedge clk);
         #1;
         if (acc) break;
         waited++;
         if (waited > 200) begin
            chk("in_accept_timeout", waited, 0);
            break;
         end
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_pkt(input bit jitter);
      int dest;
      dest = model_dest();
      if (dest == D_DATA) foreach (pkt[i]) exp_m.push_back(pkt[i]);
      else if (dest == D_CTRL) begin
         foreach (pkt[i]) exp_c.push_back(pkt[i]);
         exp_ctrl++;
      end else exp_drop++;
      foreach (pkt[i]) begin
         if (jitter && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         send_beat(pkt[i]);
      end
   endtask

   task automatic drain();
      int w = 0;
      while ((exp_m.size() != 0 || exp_c.size() != 0) && w < 500) begin
         idle(1);
         w++;
      end
      idle(3);
      chk("drain_m_empty", exp_m.size(), 0);
      chk("drain_c_empty", exp_c.size(), 0);
   endtask

   task automatic do_reset(input int n);
      areset        = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("rst_tready_low", s_axis_tready, 0);
         @(posedge clk);
         #1;
      end
      areset = 1'b0;
      exp_m.delete();
      exp_c.delete();
      exp_drop = 0;
      exp_ctrl = 0;
      @(negedge clk);
      chk("rst_tready_after", s_axis_tready, 1);
      chk("rst_m_out", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast}, 0);
      chk("rst_c_out", {c_m_axis_tvalid, c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast}, 0);
      chk("rst_counters", {drop_cnt, ctrl_cnt}, 0);
      @(posedge clk);
      #1;
   endtask

   // Output scoreboards and stall-stability checks.
   initial begin
      beat_t cur_m, cur_c, prev_m, prev_c;
      bit    m_stall = 1'b0;
      bit    c_stall = 1'b0;
      prev_m = '0;
      prev_c = '0;
      forever begin
         @(negedge clk);
         if (areset) begin
            m_stall = 1'b0;
            c_stall = 1'b0;
         end else begin
            cur_m = {m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast};
            cur_c = {c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast};
            if (m_stall) chk("m_stable", {m_axis_tvalid, cur_m}, {1'b1, prev_m});
            if (c_stall) chk("c_stable", {c_m_axis_tvalid, cur_c}, {1'b1, prev_c});
            if (m_axis_tvalid && !m_stall) m_app.push_back(cyc);
            if (m_axis_tvalid && m_axis_tready) begin
               chk("m_beat_expected", exp_m.size() != 0, 1);
               if (exp_m.size() != 0) chk("m_beat", cur_m, exp_m.pop_front());
            end
            if (c_m_axis_tvalid && c_m_axis_tready) begin
               chk("c_beat_expected", exp_c.size() != 0, 1);
               if (exp_c.size() != 0) chk("c_beat", cur_c, exp_c.pop_front());
            end
            m_stall = m_axis_tvalid && !m_axis_tready;
            c_stall = c_m_axis_tvalid && !c_m_axis_tready;
            prev_m  = cur_m;
            prev_c  = cur_c;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) begin
            m_axis_tready   = ($urandom_range(0, 3) != 0);
            c_m_axis_tready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      beat_t b0, b1, b2, b3;
      do_reset(3);

      // 3-beat data packet at full rate
      acc_cyc.delete();
      m_app.delete();
      build_pkt(3, 1, 1, 1, 0);
      send_pkt(0);
      drain();
      chk("data3_app_count", m_app.size(), 3);
      if (m_app.size() >= 2 && acc_cyc.size() >= 3) begin
         chk("data3_beat0_lat", m_app[0], acc_cyc[1] + 1);
         chk("data3_beat1_lat", m_app[1], acc_cyc[2] + 1);
      end
      chk("data3_counters", {drop_cnt, ctrl_cnt}, 0);

      // 2-beat control packet
      build_pkt(2, 1, 1, 1, 1);
      send_pkt(0);
      drain();
      chk("ctrl2_ctrl_cnt", ctrl_cnt, 1);
      chk("ctrl2_drop_cnt", drop_cnt, 0);

      // 4-beat packet without VLAN
      in_stalls = 0;
      pkt.delete();
      build_pkt(4, 0, 1, 1, 1);
      send_pkt(0);
      drain();
      chk("drop4_no_stall", in_stalls, 0);
      chk("drop4_drop_cnt", drop_cnt, 1);

      // data packet with a 5-cycle downstream stall
      build_pkt(6, 1, 1, 1, 0);
      fork
         send_pkt(0);
         begin
            int  w = 0;
            bit  seen = 1'b0;
            while (!seen && w < 50) begin
               @(negedge clk);
               seen = m_axis_tvalid;
               @(posedge clk);
               #1;
               w++;
            end
            chk("stall_out_seen", seen, 1);
            m_axis_tready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (i == 1) chk("stall_in_tready", s_axis_tready, 0);
               @(posedge clk);
               #1;
            end
            m_axis_tready = 1'b1;
         end
      join
      drain();

      // single-beat VLAN packet followed back-to-back by a control packet
      acc_cyc.delete();
      m_app.delete();
      build_pkt(1, 1, 1, 1, 0);
      send_pkt(0);
      build_pkt(2, 1, 1, 1, 1);
      send_pkt(0);
      drain();
      if (m_app.size() >= 1 && acc_cyc.size() >= 2) begin
         chk("single_lat", m_app[0], acc_cyc[0] + 1);
         chk("single_b2b_accept", acc_cyc[1], acc_cyc[0] + 1);
      end
      chk("single_ctrl_cnt", ctrl_cnt, exp_ctrl);

      // reset while forwarding a control packet
      do_reset(1);
      build_pkt(4, 1, 1, 1, 1);
      b0 = pkt[0];
      b1 = pkt[1];
      b2 = pkt[2];
      b3 = pkt[3];
      b2.d[96 +: 16] = 16'h0008;
      send_beat(b0);
      send_beat(b1);
      chk("fwdc_c_valid", c_m_axis_tvalid, 1);
      chk("fwdc_ctrl_cnt", ctrl_cnt, 1);
      do_reset(1);
      send_beat(b2);
      send_beat(b3);
      idle(3);
      chk("fwdc_after_drop_cnt", drop_cnt, 1);
      chk("fwdc_after_ctrl_cnt", ctrl_cnt, 0);
      exp_drop = 1;

      // randomized traffic with random downstream readiness
      rand_ready = 1'b1;
      for (int p = 0; p < 60; p++) begin
         build_pkt($urandom_range(1, 4), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
         send_pkt($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();
      rand_ready      = 1'b0;
      m_axis_tready   = 1'b1;
      c_m_axis_tready = 1'b1;
      idle(2);
      chk("final_drop_cnt", drop_cnt, exp_drop);
      chk("final_ctrl_cnt", ctrl_cnt, exp_ctrl);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pkt_filter.md
# pkt_filter

Ingress classifier sitting directly upstream of the parser and its control chain. It accepts the 256-bit AXI-Stream from the MAC/DMA side and inspects the Ethernet, VLAN, IPv4 and UDP headers. Each packet is then steered whole to the data output (parser plus packet buffer), steered to the control output (parser control chain), or dropped. Drop and control-packet counts are exported for status registers.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, stream data width; only 256 supported.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width; carried unmodified.
- CTRL_UDP_PORT, 16'hf2f1, UDP dst port identifying control packets, in wire-byte-swapped form (as seen at tdata[64+:16] of beat 1).
- Clock and reset: one clock; reset is synchronous and active-high.
- axis_clk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- s_axis_tdata/tuser/tkeep/tvalid/tlast  in  256/128/32/1/1  ingress stream.
- s_axis_tready  out  1  ingress ready.
- m_axis_tdata/tuser/tkeep/tvalid/tlast  out  256/128/32/1/1  data-path stream.
- m_axis_tready  in  1  data-path ready.
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  256/128/32/1/1  control-path stream.
- c_m_axis_tready  in  1  control-path ready.
- drop_cnt  out  32  packets dropped, saturating.
- ctrl_cnt  out  32  packets sent to control output, saturating.

## Operation
- Header fields are taken from the tdata bit positions below; byte 0 is at [7:0].
- Beat 0 fields:
  - TPID at [96+:16]; 16'h0081 means VLAN present.
  - Ethertype at [128+:16]; 16'h0008 means IPv4.
  - IP protocol at [216+:8]; 8'h11 means UDP.
- Beat 1 field: UDP dst port at [64+:16].
- Classification rules:
  - No VLAN tag: the packet is dropped.
  - VLAN, IPv4, UDP, and dport == CTRL_UDP_PORT: control output.
  - Any other VLAN packet: data output.
  - Single-beat packet (tlast on beat 0): data output if VLAN is present, else dropped. It is never sent to control.
- Storage:
  - One hold register (beat + valid) for all sideband fields.
  - One output register per channel.
- States:
  - IDLE: s_axis_tready=1 while hold is empty.
    - Beat 0 accepted without tlast: store it in hold, go to CLASSIFY.
    - Beat 0 accepted with tlast: classify immediately; load the chosen output register (or discard); stay in IDLE.
  - CLASSIFY: wait for beat 1; decide the destination on its handshake.
    - The held beat 0 moves to the chosen output register (or is discarded for DROP) in the same cycle beat 1 enters hold.
    - Next state is FWD_DATA, FWD_CTRL or DROP.
    - If beat 1 carries tlast: return to IDLE once hold drains.
  - FWD_DATA / FWD_CTRL: the hold-to-output pipeline runs each cycle.
    - Hold moves to the output register when that register is empty or its tready=1.
    - s_axis_tready=1 when hold is empty or moves this cycle.
    - After the tlast beat leaves hold, go to IDLE.
  - DROP: s_axis_tready=1; beats are discarded. On the accepted tlast, go to IDLE.
- Backpressure rules:
  - Output valid/data hold stable until tready.
  - The unused output is never asserted.
  - A stalled output stalls ingress only through hold.
- Counters:
  - drop_cnt increments by 1 per dropped packet, at the drop decision.
  - ctrl_cnt increments by 1 per packet routed to control, at the decision.
  - Both saturate at 32'hffffffff.
- tuser, tkeep and tlast travel with their beat unmodified.

## Timing
- Reset values:
  - All tvalid = 0; all tdata/tuser/tkeep/tlast = 0.
  - s_axis_tready = 0 during reset, 1 in the first cycle after.
  - drop_cnt = ctrl_cnt = 0.
  - State IDLE; hold empty.
- Reset mid-packet discards all held and output beats. Subsequent beats of that packet are treated as a new packet starting at beat 0.
- Latency:
  - Multi-beat packet: beat 0 appears on the output 1 cycle after the beat-1 handshake.
  - Steady state: beat N appears 1 cycle after beat N+1 is accepted; the tlast beat appears 1 cycle after its own acceptance.
  - Single-beat packet: appears 1 cycle after acceptance.
- Throughput: 1 beat/cycle with tready held high. An IDLE-entry bubble of at most 1 cycle between packets is allowed.
- The tlast beat and the next packet's beat 0 may be accepted on consecutive cycles.

## Test plan
- 3-beat VLAN/IPv4/UDP packet, dport ≠ CTRL_UDP_PORT, m_axis_tready=1:
  - Beats appear on m_axis in order, 1 cycle after the following beat (the last 1 cycle after itself).
  - c_m_axis_tvalid stays 0; counters stay 0.
- 2-beat control packet with dport == 16'hf2f1: both beats appear on c_m_axis; ctrl_cnt = 1; m_axis_tvalid stays 0.
- Packet with TPID 16'h0008 (no VLAN), 4 beats: s_axis_tready stays 1; no output valid; drop_cnt = 1.
- Data packet with m_axis_tready low for 5 cycles mid-packet:
  - Output data is stable while stalled; s_axis_tready drops within 1 cycle.
  - No beat is lost or duplicated; tlast lands on the final beat.
- Single-beat VLAN packet (tlast on beat 0), then back-to-back another packet: first goes to m_axis with tlast=1; second is classified independently.
- areset asserted during FWD_CTRL: all tvalid = 0 next cycle and counters are 0. The remaining beats are classified as a fresh packet (a non-VLAN beat 0 is dropped, drop_cnt = 1).
